// File: rtl/counter_7seg_mux.sv
// counter_7seg_mux: multi-digit BCD up/down counter with a tick prescaler,
// load/clear, and a time-multiplexed 7-segment display driver.
// Optional feature macro: LEADING_ZERO_BLANK_EN blanks digits above the most
// significant nonzero digit (digit 0 is never blanked).
module counter_7seg_mux #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 50_000_000,
  parameter int SCAN_DIV = 50_000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_up,
  input  logic                  i_clear,
  input  logic                  i_load,
  input  logic [4*DIGITS-1:0]   i_load_val,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic                  o_carry,
  output logic [DIGITS-1:0]     o_anode,
  output logic [6:0]            o_segment
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [4*DIGITS-1:0] r_bcd;
  logic                r_carry;
  logic [TW-1:0]       r_tickCnt;
  logic [SW-1:0]       r_scanCnt;
  logic [IW-1:0]       r_scanIdx;
  logic [DIGITS-1:0]   r_anode;
  logic [6:0]          r_segment;

  logic                w_tickWrap;
  logic                w_scanWrap;
  logic [4*DIGITS-1:0] w_stepBcd;
  logic                w_stepWrap;
  logic [4*DIGITS-1:0] w_loadBcd;
  logic [IW-1:0]       w_nextScanIdx;
  logic [3:0]          w_digitSel;
  logic                w_blankSel;
  logic [DIGITS-1:0]   w_blank;

  function automatic logic [6:0] decodeDigit(input logic [3:0] digit);
    case (digit)
      4'd0:    decodeDigit = 7'h3F;
      4'd1:    decodeDigit = 7'h06;
      4'd2:    decodeDigit = 7'h5B;
      4'd3:    decodeDigit = 7'h4F;
      4'd4:    decodeDigit = 7'h66;
      4'd5:    decodeDigit = 7'h6D;
      4'd6:    decodeDigit = 7'h7D;
      4'd7:    decodeDigit = 7'h07;
      4'd8:    decodeDigit = 7'h7F;
      4'd9:    decodeDigit = 7'h6F;
      default: decodeDigit = 7'h00;
    endcase
  endfunction

  assign w_tickWrap = (r_tickCnt == TW'(TICK_DIV - 1));
  assign w_scanWrap = (r_scanCnt == SW'(SCAN_DIV - 1));

  // Next count value for one step: ripple increment or borrow decrement across digits
  always_comb begin : stepCalc
    logic       ripple;
    logic [3:0] dig;
    ripple    = 1'b1;
    w_stepBcd = r_bcd;
    for (int d = 0; d < DIGITS; d++) begin
      dig = r_bcd[4*d +: 4];
      if (ripple) begin
        if (i_up) begin
          if (dig == 4'd9) begin
            w_stepBcd[4*d +: 4] = 4'd0;
          end else begin
            w_stepBcd[4*d +: 4] = dig + 4'd1;
            ripple = 1'b0;
          end
        end else begin
          if (dig == 4'd0) begin
            w_stepBcd[4*d +: 4] = 4'd9;
          end else begin
            w_stepBcd[4*d +: 4] = dig - 4'd1;
            ripple = 1'b0;
          end
        end
      end
    end
    w_stepWrap = ripple;
  end

  // Sanitise the load value so that any non-decimal digit is taken as zero
  always_comb begin
    w_loadBcd = '0;
    for (int d = 0; d < DIGITS; d++) begin
      if (i_load_val[4*d +: 4] <= 4'd9) begin
        w_loadBcd[4*d +: 4] = i_load_val[4*d +: 4];
      end
    end
  end

  // Count register and tick prescaler; clear and load discard a coincident step
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bcd     <= '0;
      r_carry   <= 1'b0;
      r_tickCnt <= '0;
    end else if (i_clear) begin
      r_bcd     <= '0;
      r_carry   <= 1'b0;
      r_tickCnt <= '0;
    end else if (i_load) begin
      r_bcd     <= w_loadBcd;
      r_carry   <= 1'b0;
      r_tickCnt <= '0;
    end else begin
      r_carry <= 1'b0;
      if (i_en) begin
        if (w_tickWrap) begin
          r_tickCnt <= '0;
          r_bcd     <= w_stepBcd;
          r_carry   <= w_stepWrap;
        end else begin
          r_tickCnt <= r_tickCnt + 1'b1;
        end
      end
    end
  end

  // Scan index advances on each scan prescaler wrap, cycling through all digits
  always_comb begin
    w_nextScanIdx = r_scanIdx;
    if (w_scanWrap) begin
      w_nextScanIdx = (r_scanIdx == IW'(DIGITS - 1)) ? '0 : r_scanIdx + 1'b1;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is blank when it and every more significant digit are zero, except digit 0
  always_comb begin : blankCalc
    logic zeros;
    zeros   = 1'b1;
    w_blank = '0;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      zeros = zeros & (r_bcd[4*d +: 4] == 4'd0);
      w_blank[d] = zeros && (d != 0);
    end
  end
`else
  assign w_blank = '0;
`endif

  // Select the digit that will be shown after this edge, using the current count
  always_comb begin
    w_digitSel = '0;
    w_blankSel = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (IW'(d) == w_nextScanIdx) begin
        w_digitSel = r_bcd[4*d +: 4];
        w_blankSel = w_blank[d];
      end
    end
  end

  // Scan prescaler, index and registered anode/segment drive, independent of en/clear/load
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_scanCnt <= '0;
      r_scanIdx <= '0;
      r_anode   <= DIGITS'(1);
      r_segment <= 7'h3F;
    end else begin
      r_scanCnt <= w_scanWrap ? '0 : r_scanCnt + 1'b1;
      r_scanIdx <= w_nextScanIdx;
      r_anode   <= DIGITS'(1) << w_nextScanIdx;
      r_segment <= w_blankSel ? 7'h00 : decodeDigit(w_digitSel);
    end
  end

  assign o_bcd     = r_bcd;
  assign o_carry   = r_carry;
  assign o_anode   = r_anode;
  assign o_segment = r_segment;

endmodule

// File: tb/tb_counter_7seg_mux.sv
// tb_counter_7seg_mux: directed self-checking bench for counter_7seg_mux
// with DIGITS=2, TICK_DIV=4, SCAN_DIV=2.
module tb_counter_7seg_mux;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up;
  logic       clear;
  logic       load;
  logic [7:0] loadVal;
  logic [7:0] bcd;
  logic       carry;
  logic [1:0] anode;
  logic [6:0] segment;

  int checkCount = 0;
  int errorCount = 0;

  logic [6:0] blankDigit1;

  counter_7seg_mux #(
    .DIGITS   (2),
    .TICK_DIV (4),
    .SCAN_DIV (2)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_en       (en),
    .i_up       (up),
    .i_clear    (clear),
    .i_load     (load),
    .i_load_val (loadVal),
    .o_bcd      (bcd),
    .o_carry    (carry),
    .o_anode    (anode),
    .o_segment  (segment)
  );

  // Free-running board clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one set of inputs, then let the given number of rising edges pass
  task automatic applyStimulus(input logic r, input logic e, input logic u,
                               input logic c, input logic l,
                               input logic [7:0] v, input int cycles);
    rst     = r;
    en      = e;
    up      = u;
    clear   = c;
    load    = l;
    loadVal = v;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Compare one observed value against its expected value and log a mismatch
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Directed test sequence
  initial begin
`ifdef LEADING_ZERO_BLANK_EN
    blankDigit1 = 7'h00;
`else
    blankDigit1 = 7'h3F;
`endif
    rst = 1'b1; en = 1'b0; up = 1'b0; clear = 1'b0; load = 1'b0; loadVal = 8'h00;

    applyStimulus(1, 0, 0, 0, 0, 8'h00, 2);
    checkOutput("reset_bcd", bcd, 8'h00);
    checkOutput("reset_carry", carry, 0);
    checkOutput("reset_anode", anode, 2'b01);
    checkOutput("reset_segment", segment, 7'h3F);

    applyStimulus(0, 1, 1, 0, 0, 8'h00, 3);
    checkOutput("up_before_step", bcd, 8'h00);
    applyStimulus(0, 1, 1, 0, 0, 8'h00, 1);
    checkOutput("up_first_step", bcd, 8'h01);
    checkOutput("up_first_carry", carry, 0);
    applyStimulus(0, 1, 1, 0, 0, 8'h00, 4);
    checkOutput("up_second_step", bcd, 8'h02);

    applyStimulus(0, 1, 1, 0, 1, 8'h98, 1);
    checkOutput("load_98", bcd, 8'h98);
    applyStimulus(0, 1, 1, 0, 0, 8'h00, 4);
    checkOutput("up_to_99", bcd, 8'h99);
    checkOutput("up_99_carry", carry, 0);
    applyStimulus(0, 1, 1, 0, 0, 8'h00, 4);
    checkOutput("up_wrap_bcd", bcd, 8'h00);
    checkOutput("up_wrap_carry", carry, 1);
    applyStimulus(0, 1, 1, 0, 0, 8'h00, 1);
    checkOutput("up_carry_drop", carry, 0);
    checkOutput("up_wrap_hold", bcd, 8'h00);

    applyStimulus(1, 1, 0, 0, 0, 8'h00, 1);
    applyStimulus(0, 1, 0, 0, 0, 8'h00, 3);
    checkOutput("down_before_step", bcd, 8'h00);
    applyStimulus(0, 1, 0, 0, 0, 8'h00, 1);
    checkOutput("down_wrap_bcd", bcd, 8'h99);
    checkOutput("down_wrap_carry", carry, 1);
    applyStimulus(0, 1, 0, 0, 0, 8'h00, 1);
    checkOutput("down_carry_drop", carry, 0);
    applyStimulus(0, 1, 0, 0, 0, 8'h00, 2);
    checkOutput("down_hold_99", bcd, 8'h99);
    applyStimulus(0, 1, 0, 0, 0, 8'h00, 1);
    checkOutput("down_to_98", bcd, 8'h98);

    applyStimulus(0, 1, 1, 0, 0, 8'h00, 3);
    checkOutput("pre_collision", bcd, 8'h98);
    applyStimulus(0, 1, 1, 0, 1, 8'h12, 1);
    checkOutput("load_beats_step", bcd, 8'h12);
    checkOutput("load_no_carry", carry, 0);
    applyStimulus(0, 1, 1, 0, 0, 8'h00, 3);
    checkOutput("load_resets_tick", bcd, 8'h12);
    applyStimulus(0, 1, 1, 0, 0, 8'h00, 1);
    checkOutput("step_after_load", bcd, 8'h13);

    applyStimulus(0, 0, 1, 0, 1, 8'h4C, 1);
    checkOutput("load_4C", bcd, 8'h40);
    applyStimulus(0, 0, 1, 0, 1, 8'hA7, 1);
    checkOutput("load_A7", bcd, 8'h07);
    applyStimulus(0, 0, 1, 1, 1, 8'h55, 1);
    checkOutput("clear_beats_load", bcd, 8'h00);

    applyStimulus(0, 1, 1, 0, 1, 8'h00, 1);
    applyStimulus(0, 1, 1, 0, 0, 8'h00, 2);
    applyStimulus(0, 0, 1, 0, 0, 8'h00, 10);
    checkOutput("en_low_hold", bcd, 8'h00);
    applyStimulus(0, 1, 1, 0, 0, 8'h00, 1);
    checkOutput("en_resume_wait", bcd, 8'h00);
    applyStimulus(0, 1, 1, 0, 0, 8'h00, 1);
    checkOutput("en_resume_step", bcd, 8'h01);

    applyStimulus(1, 0, 0, 0, 0, 8'h00, 1);
    applyStimulus(0, 0, 0, 0, 1, 8'h37, 1);
    checkOutput("scan37_lag_anode", anode, 2'b01);
    checkOutput("scan37_lag_segment", segment, 7'h3F);
    for (int k = 2; k < 10; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 8'h00, 1);
      if (((k / 2) % 2) == 1) begin
        checkOutput("scan37_anode_d1", anode, 2'b10);
        checkOutput("scan37_segment_d1", segment, 7'h4F);
      end else begin
        checkOutput("scan37_anode_d0", anode, 2'b01);
        checkOutput("scan37_segment_d0", segment, 7'h07);
      end
    end

    applyStimulus(1, 0, 0, 0, 0, 8'h00, 1);
    applyStimulus(0, 0, 0, 0, 1, 8'h05, 1);
    checkOutput("scan05_lag_segment", segment, 7'h3F);
    for (int k = 2; k < 8; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 8'h00, 1);
      if (((k / 2) % 2) == 1) begin
        checkOutput("scan05_anode_d1", anode, 2'b10);
        checkOutput("scan05_segment_d1", segment, blankDigit1);
      end else begin
        checkOutput("scan05_anode_d0", anode, 2'b01);
        checkOutput("scan05_segment_d0", segment, 7'h6D);
      end
    end

    applyStimulus(1, 0, 0, 0, 0, 8'h00, 1);
    checkOutput("rst_mid_scan_anode", anode, 2'b01);
    checkOutput("rst_mid_scan_segment", segment, 7'h3F);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
